pwm_multi_chan: RTL

- Parametrised successor to the single-channel PWM controller: NCH independent PWM channels share one WIDTH-bit timebase.
- Programmable period (TOP) and edge- or center-aligned counting.
- Duty, period and mode are written through a simple register write port into staging registers. They are shadow-loaded atomically at the period boundary, so output waveforms never glitch.
- Sits behind the tt_um top-level wrapper, driven from the ui_in/uio_in pins; drives uo_out.

---
 rtl/pwm_multi_chan.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwm_multi_chan.sv
// NCH PWM channels sharing one WIDTH-bit edge/center-aligned timebase; duty/TOP/mode are shadowed to the period boundary.
// Defining PWM_DEADTIME_EN adds complementary pwm_out_n outputs with DEADTIME-cycle dead-time insertion.
module pwm_multi_chan #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int ADDR_W   = 3,
  parameter int DEADTIME = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NCH-1:0]    pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic [NCH-1:0]    pwm_out_n,
`endif
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(NCH);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(NCH + 1);
  localparam logic [WIDTH-1:0]  TOP_RST   = '1;
  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0]  TWO       = WIDTH'(2);

  if (DEADTIME < 1 || DEADTIME > 15 || (1 << ADDR_W) < NCH + 2) begin : g_bad_cfg
    $error("pwm_multi_chan: unsupported parameter combination");
  end

  logic [WIDTH-1:0] cnt_reg;
  logic             dir_down_reg;
  logic [WIDTH-1:0] duty_stg_reg [NCH];
  logic [WIDTH-1:0] duty_act_reg [NCH];
  logic [WIDTH-1:0] top_stg_reg;
  logic [WIDTH-1:0] top_act_reg;
  logic             mode_stg_reg;
  logic             mode_act_reg;
  logic             center_eff;
  logic             period_end;
  logic [NCH-1:0]   raw;

  // Center counting needs at least one down step; below TOP=2 it degenerates to edge mode.
  assign center_eff = mode_act_reg && (top_act_reg >= TWO);
  assign period_end = center_eff ? (dir_down_reg && (cnt_reg == ONE))
                                 : (cnt_reg == top_act_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) duty_stg_reg[i] <= '0;
      top_stg_reg  <= TOP_RST;
      mode_stg_reg <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_addr == ADDR_W'(i)) duty_stg_reg[i] <= wr_data;
      end
      if (wr_addr == ADDR_TOP)  top_stg_reg  <= wr_data;
      if (wr_addr == ADDR_CTRL) mode_stg_reg <= wr_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      dir_down_reg <= 1'b0;
      top_act_reg  <= TOP_RST;
      mode_act_reg <= 1'b0;
      for (int i = 0; i < NCH; i++) duty_act_reg[i] <= '0;
      period_tick  <= 1'b0;
    end else if (!ena || period_end) begin
      // While idle the shadows track staging so the first enabled period uses current values.
      cnt_reg      <= '0;
      dir_down_reg <= 1'b0;
      top_act_reg  <= top_stg_reg;
      mode_act_reg <= mode_stg_reg;
      for (int i = 0; i < NCH; i++) duty_act_reg[i] <= duty_stg_reg[i];
      period_tick  <= ena && period_end;
    end else begin
      period_tick <= 1'b0;
      if (dir_down_reg) begin
        cnt_reg <= cnt_reg - ONE;
      end else if (center_eff && (cnt_reg == top_act_reg)) begin
        dir_down_reg <= 1'b1;
        cnt_reg      <= cnt_reg - ONE;
      end else begin
        cnt_reg <= cnt_reg + ONE;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
    assign raw[gi] = (cnt_reg < duty_act_reg[gi]);
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [3:0] DT = 4'(DEADTIME);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_dt
    logic [3:0] dt_reg;
    logic [3:0] dt_next;
    logic       raw_q_reg;
    logic       vld_reg;
    logic       out_p_reg;
    logic       out_n_reg;
    logic       stable;

    // vld_reg makes the first sample after reset/idle count as an edge, like any raw change.
    assign stable  = vld_reg && (raw[gi] == raw_q_reg);
    assign dt_next = (dt_reg >= DT) ? DT : dt_reg + 4'd1;

    always_ff @(posedge clk) begin
      if (!rst_n || !ena) begin
        dt_reg    <= '0;
        raw_q_reg <= 1'b0;
        vld_reg   <= 1'b0;
        out_p_reg <= 1'b0;
        out_n_reg <= 1'b0;
      end else begin
        raw_q_reg <= raw[gi];
        vld_reg   <= 1'b1;
        if (!stable) begin
          dt_reg    <= '0;
          out_p_reg <= 1'b0;
          out_n_reg <= 1'b0;
        end else begin
          dt_reg    <= dt_next;
          out_p_reg <= raw[gi] && (dt_next == DT);
          out_n_reg <= !raw[gi] && (dt_next == DT);
        end
      end
    end

    assign pwm_out[gi]   = out_p_reg;
    assign pwm_out_n[gi] = out_n_reg;
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) pwm_out <= '0;
    else        pwm_out <= raw & {NCH{ena}};
  end
`endif

endmodule
